// File: rtl/local_history_predictor_pkg.sv
// Shared helpers for the local-history predictor: saturating counter step,
// weakly-not-taken init value and the PC index/tag split.
package bp_pkg;
  localparam int FN_W = 32;

  function automatic logic [FN_W-1:0] wnt(input int ctr_w);
    return (FN_W'(1) << (ctr_w - 1)) - FN_W'(1);
  endfunction

  // Saturating step, never wraps: sticks at 0 and at all-ones of ctr_w bits.
  function automatic logic [FN_W-1:0] sat_update(input logic [FN_W-1:0] ctr,
                                                 input logic taken,
                                                 input int ctr_w);
    logic [FN_W-1:0] max_v;
    max_v = (FN_W'(1) << ctr_w) - FN_W'(1);
    if (taken) return (ctr == max_v) ? ctr : ctr + FN_W'(1);
    return (ctr == '0) ? ctr : ctr - FN_W'(1);
  endfunction

  function automatic logic [FN_W-1:0] addr_idx(input logic [FN_W-1:0] addr, input int idx_w);
    return addr & ((FN_W'(1) << idx_w) - FN_W'(1));
  endfunction

  function automatic logic [FN_W-1:0] addr_tag(input logic [FN_W-1:0] addr, input int idx_w);
    return addr >> idx_w;
  endfunction
endpackage

// File: rtl/local_history_predictor_pht_entry.sv
// Counter array of one BHT entry: 2**HIST_W saturating counters, read and
// trained at the entry's current history, bulk-reinitialised on allocate.
module pht_entry
  import bp_pkg::*;
#(
  parameter int HIST_W = 3,
  parameter int CTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HIST_W-1:0] rd_idx,
  input  logic [HIST_W-1:0] tr_idx,
  input  logic              tr_en,
  input  logic              taken,
  input  logic              init,
  output logic              rd_taken
);
  localparam int N = 2**HIST_W;
  localparam logic [CTR_W-1:0] WNT_V = CTR_W'(wnt(CTR_W));

  logic [N-1:0][CTR_W-1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (init)       ctr_d = {N{WNT_V}};
    else if (tr_en) ctr_d[tr_idx] = CTR_W'(sat_update(FN_W'(ctr_q[tr_idx]), taken, CTR_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ctr_q <= {N{WNT_V}};
    else     ctr_q <= ctr_d;
  end

  assign rd_taken = ctr_q[rd_idx][CTR_W-1];
endmodule

// File: rtl/local_history_predictor.sv
// Two-level local-history branch predictor: tagged direct-mapped BHT of
// per-branch histories, each selecting a counter in its own PHT entry.
module local_history_predictor
  import bp_pkg::*;
#(
  parameter int PC_W   = 10,
  parameter int IDX_W  = 4,
  parameter int HIST_W = 3,
  parameter int CTR_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  pc,
  output logic             prediction,
  output logic             pred_hit,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic             upd_pred,
  input  logic             flush,
  output logic             evict,
  output logic [CNT_W-1:0] mispredict_cnt
);
  localparam int ENTRIES = 2**IDX_W;
  localparam int TAG_W   = PC_W - IDX_W;

  logic [ENTRIES-1:0]             valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [ENTRIES-1:0][HIST_W-1:0] hist_q, hist_d;
  logic                           evict_q, evict_d;
  logic [CNT_W-1:0]               mp_cnt_q, mp_cnt_d;

  logic [ENTRIES-1:0] rd_taken, tr_en, init;
  logic [IDX_W-1:0]   rd_idx, up_idx;
  logic [TAG_W-1:0]   rd_tag, up_tag;
  logic               up_hit, do_upd;

  assign rd_idx = IDX_W'(addr_idx(FN_W'(pc), IDX_W));
  assign rd_tag = TAG_W'(addr_tag(FN_W'(pc), IDX_W));
  assign up_idx = IDX_W'(addr_idx(FN_W'(upd_pc), IDX_W));
  assign up_tag = TAG_W'(addr_tag(FN_W'(upd_pc), IDX_W));

  assign pred_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign prediction = pred_hit && rd_taken[rd_idx];

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign do_upd = upd_valid && !flush;

  // Each entry reads and trains at its own history; the top picks by index.
  for (genvar e = 0; e < ENTRIES; e++) begin : g_pht
    assign tr_en[e] = do_upd &&  up_hit && (up_idx == IDX_W'(e));
    assign init[e]  = do_upd && !up_hit && (up_idx == IDX_W'(e));
    pht_entry #(.HIST_W(HIST_W), .CTR_W(CTR_W)) u_pht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (hist_q[e]),
      .tr_idx   (hist_q[e]),
      .tr_en    (tr_en[e]),
      .taken    (upd_taken),
      .init     (init[e]),
      .rd_taken (rd_taken[e])
    );
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    hist_d   = hist_q;
    evict_d  = 1'b0;
    mp_cnt_d = mp_cnt_q;
    if (flush) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        hist_d[up_idx] = {hist_q[up_idx][HIST_W-2:0], upd_taken};
      end else begin
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        hist_d[up_idx]  = {{(HIST_W-1){1'b0}}, upd_taken};
        evict_d         = valid_q[up_idx];
      end
      if ((upd_pred != upd_taken) && (mp_cnt_q != '1)) mp_cnt_d = mp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      tag_q    <= '0;
      hist_q   <= '0;
      evict_q  <= 1'b0;
      mp_cnt_q <= '0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      hist_q   <= hist_d;
      evict_q  <= evict_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign evict          = evict_q;
  assign mispredict_cnt = mp_cnt_q;
endmodule

// File: tb/tb_local_history_predictor.sv
// Directed bench for local_history_predictor: hand-derived expectations are
// queued with each stimulus step and compared once the DUT responds.
module tb_local_history_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pc;
  logic        prediction, pred_hit;
  logic        upd_valid;
  logic [9:0]  upd_pc;
  logic        upd_taken, upd_pred, flush;
  logic        evict;
  logic [15:0] mispredict_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic        hit;
    logic        pred;
    logic        ev;
    logic [15:0] cnt;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  local_history_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .prediction     (prediction),
    .pred_hit       (pred_hit),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_pred       (upd_pred),
    .flush          (flush),
    .evict          (evict),
    .mispredict_cnt (mispredict_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic h, input logic p, input logic ev,
                      input logic [15:0] c);
    exp_t e;
    e.tag = tag; e.hit = h; e.pred = p; e.ev = ev; e.cnt = c;
    sbq.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++; failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sbq.pop_front();
    chk({e.tag, ".hit"},  16'(pred_hit),   16'(e.hit));
    chk({e.tag, ".pred"}, 16'(prediction), 16'(e.pred));
    chk({e.tag, ".evict"}, 16'(evict),     16'(e.ev));
    chk({e.tag, ".cnt"},  mispredict_cnt,  e.cnt);
  endtask

  // One clocked step: optional update/flush, then read rd at the next cycle.
  task automatic step(input logic uv, input logic [9:0] a, input logic tk, input logic pr,
                      input logic fl, input logic [9:0] rd, input string tag,
                      input logic h, input logic p, input logic ev, input logic [15:0] c);
    upd_valid = uv; upd_pc = a; upd_taken = tk; upd_pred = pr; flush = fl;
    push(tag, h, p, ev, c);
    @(posedge clk);
    #1;
    upd_valid = 1'b0; flush = 1'b0; pc = rd;
    #1;
    pop_check();
  endtask

  // Combinational read in the current cycle, no clock edge.
  task automatic rd_now(input logic [9:0] rd, input string tag, input logic h, input logic p,
                        input logic ev, input logic [15:0] c);
    pc = rd;
    push(tag, h, p, ev, c);
    #1;
    pop_check();
  endtask

  initial begin
    rst = 1'b1; pc = 10'h025; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_pred = 1'b0; flush = 1'b0;
    #1;
    rd_now(10'h025, "in_reset", 0, 0, 0, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd_now(10'h025, "post_reset", 0, 0, 0, 16'd0);

    // allocate entry 5 with tag 2, then train towards taken
    step(1, 10'h025, 1, 0, 0, 10'h025, "alloc",  1, 0, 0, 16'd1);
    step(1, 10'h025, 1, 0, 0, 10'h025, "train2", 1, 0, 0, 16'd2);
    step(1, 10'h025, 1, 1, 0, 10'h025, "train3", 1, 0, 0, 16'd2);
    for (int i = 0; i < 5; i++)
      step(1, 10'h025, 1, 1, 0, 10'h025, $sformatf("sat_up%0d", i), 1, 1, 0, 16'd2);
    for (int i = 0; i < 5; i++)
      step(1, 10'h025, 0, 1, 0, 10'h025, $sformatf("sat_dn%0d", i), 1, 0, 0, 16'(3 + i));
    // history walks 001, 011, 111 over counters trained to 10 earlier
    step(1, 10'h025, 1, 0, 0, 10'h025, "hist001", 1, 1, 0, 16'd8);
    step(1, 10'h025, 1, 1, 0, 10'h025, "hist011", 1, 1, 0, 16'd8);
    step(1, 10'h025, 1, 1, 0, 10'h025, "hist111", 1, 1, 0, 16'd8);

    // eviction by same index, different tag
    step(1, 10'h035, 0, 0, 0, 10'h035, "evict_new", 1, 0, 1, 16'd8);
    rd_now(10'h025, "evict_old", 0, 0, 1, 16'd8);
    step(0, 10'h000, 0, 0, 0, 10'h035, "evict_pulse_end", 1, 0, 0, 16'd8);
    step(1, 10'h035, 1, 0, 0, 10'h035, "init_ctr1", 1, 0, 0, 16'd9);
    step(1, 10'h035, 1, 0, 0, 10'h035, "init_ctr3", 1, 0, 0, 16'd10);

    // flush wins over a simultaneous mispredicted update
    step(1, 10'h035, 1, 0, 1, 10'h035, "flush", 0, 0, 0, 16'd10);
    rd_now(10'h025, "flush_other", 0, 0, 0, 16'd10);
    rd_now(10'h026, "never_alloc", 0, 0, 0, 16'd10);
    step(1, 10'h035, 0, 0, 0, 10'h035, "realloc", 1, 0, 0, 16'd10);

    // drive the mispredict counter well past saturation
    upd_valid = 1'b1; upd_pc = 10'h035; upd_taken = 1'b0; upd_pred = 1'b1;
    repeat (65539) @(posedge clk);
    #1 upd_valid = 1'b0;
    rd_now(10'h035, "cnt_sat", 1, 0, 0, 16'hFFFF);
    step(1, 10'h035, 1, 0, 0, 10'h035, "cnt_hold", 1, 0, 0, 16'hFFFF);

    // async reset mid-cycle while an update is presented
    upd_valid = 1'b1; upd_pc = 10'h035; upd_taken = 1'b1; upd_pred = 1'b0; pc = 10'h035;
    #1 rst = 1'b1;
    rd_now(10'h035, "async_rst", 0, 0, 0, 16'd0);
    @(posedge clk);
    #1 upd_valid = 1'b0;
    rst = 1'b0;
    rd_now(10'h035, "after_rst", 0, 0, 0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
